mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning ACCESS cycles without dmem_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX result present this cycle.
- in_mem_write_enable  in  1  store instruction.
- in_wb_res_mux  in  2  write-back source; 2'b01 = load, other values = ALU result.
- in_reg_write_enable  in  1  instruction writes the register file.
- in_fl_write_enable  in  1  instruction updates the flag register.
- in_alu_out  in  32  ALU result.
- in_alu_flags  in  6  ALU flags; bit 5 is carry-out.
- in_mem_addr  in  32  memory address (rs data).
- in_mem_data  in  32  store data (rt data).
- in_reg_dst  in  5  destination register.
- stall  out  1  EX must hold its outputs; instruction not accepted.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  32  request address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.
- dmem_ack  in  1  memory completes the request this cycle.
- wb_valid  out  1  one-cycle retire pulse to WB.
- wb_reg_write_enable  out  1  WB writes wb_data to wb_reg_dst.
- wb_reg_dst  out  5  WB destination register.
- wb_data  out  32  WB data.
- flags_out  out  6  flag register contents.
- mem_error  out  1  one-cycle pulse, access aborted on timeout.

Function
REQ-003 SHALL accept an instruction on a rising edge where in_valid=1 and stall=0; stall SHALL equal (state==ACCESS), combinationally.
REQ-004 Memory op = in_mem_write_enable | (in_wb_res_mux==2'b01); a store takes priority if both are set.
REQ-005 SHALL retire a non-memory instruction at its accept edge: wb_valid=1, wb_data=in_alu_out, wb_reg_dst=in_reg_dst, wb_reg_write_enable=in_reg_write_enable (latency 1).
REQ-006 SHALL use FSM states IDLE and ACCESS; an accepted memory op moves IDLE->ACCESS and registers dmem_req=1, dmem_we, dmem_addr, dmem_wdata and the destination at the accept edge.
REQ-007 In ACCESS, dmem_req/we/addr/wdata SHALL stay stable until a rising edge samples dmem_ack=1; that edge SHALL go to IDLE, clear dmem_req and pulse wb_valid.
REQ-008 Load retire: wb_data=dmem_rdata, wb_reg_write_enable=in_reg_write_enable as latched; store retire: wb_reg_write_enable=0, wb_data=0.
REQ-009 The earliest next acceptance after a memory op is the edge after the ack edge, so there is no write-back collision; memory-op latency is at least 2 cycles.
REQ-010 dmem_ack in IDLE SHALL be ignored.
REQ-011 wb_valid SHALL be 0 on every edge with no retirement.
REQ-012 flags_out SHALL load in_alu_flags at the accept edge when in_fl_write_enable=1, including memory ops, and SHALL otherwise hold.

Reset
REQ-013 rst=0 SHALL immediately force state IDLE and clear all outputs, flags_out and the timeout counter, regardless of clk.
REQ-014 Reset during ACCESS SHALL drop dmem_req at once and discard the pending instruction without a wb_valid pulse.

Configuration
REQ-015 With MEM_TIMEOUT_EN defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES, the block SHALL go to IDLE, drop dmem_req, pulse mem_error and pulse wb_valid with wb_reg_write_enable=0. An ack in the same cycle takes priority.
REQ-016 Without MEM_TIMEOUT_EN: ACCESS waits indefinitely, mem_error is tied 0, no counter is built.

Verification
REQ-017 ALU op: in_alu_out=0x1234, in_reg_dst=3, rwe=1 -> next edge wb_valid=1, wb_data=0x1234, wb_reg_dst=3, stall never 1.
REQ-018 Load addr 0x40, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req/addr stable 3 cycles, stall=1 throughout, wb_data=0xDEADBEEF pulse, stall 0 next cycle.
REQ-019 Store addr 0x80 data 0x55AA, ack immediate -> dmem_we=1, dmem_wdata=0x55AA, wb_valid=1 with wb_reg_write_enable=0.
REQ-020 Back-to-back load then ALU op held by stall -> ALU op retires exactly one cycle after the load retire, flags_out updated only by fl_write_enable ops.
REQ-021 rst=0 mid-ACCESS, then MEM_TIMEOUT_EN with no ack for 16 cycles -> reset: dmem_req=0 immediately, no wb_valid; timeout: mem_error=1 one cycle, wb_reg_write_enable=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX and WB. Non-memory instructions retire
// on their accept edge; loads and stores hold the pipe (stall) in ACCESS
// until the data memory acknowledges.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS watchdog that aborts
// the access after TIMEOUT_CYCLES cycles without dmem_ack.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access outstanding, EX results accepted when in_valid=1
// ACCESS | data-memory request outstanding, stall asserted
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_mem_write_enable,
   input  logic [1:0]  in_wb_res_mux,
   input  logic        in_reg_write_enable,
   input  logic        in_fl_write_enable,
   input  logic [31:0] in_alu_out,
   input  logic [5:0]  in_alu_flags,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_mem_data,
   input  logic [4:0]  in_reg_dst,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic        wb_reg_write_enable,
   output logic [4:0]  wb_reg_dst,
   output logic [31:0] wb_data,
   output logic [5:0]  flags_out,
   output logic        mem_error
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        mem_op;
   logic        ack_hit;
   logic        abort_hit;
   logic        pend_store;
   logic        pend_rwe;
   logic [4:0]  pend_dst;

   // A watchdog of zero cycles would abort every access before it starts.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
   end

   assign stall   = (state == ACCESS);
   assign accept  = in_valid & ~stall;
   assign mem_op  = in_mem_write_enable | (in_wb_res_mux == 2'b01);
   assign ack_hit = (state == ACCESS) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;

   // Abort on the edge that would make the count of ack-less cycles hit the limit.
   assign abort_hit = (state == ACCESS) & ~dmem_ack &
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count ACCESS cycles without ack; restart on every new access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (accept && mem_op) begin
         tmo_cnt <= '0;
      end else if ((state == ACCESS) && !dmem_ack && !abort_hit) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // One-cycle error pulse on the abort edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_error <= 1'b0;
      end else begin
         mem_error <= abort_hit;
      end
   end
`else
   assign abort_hit = 1'b0;
   assign mem_error = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: enter ACCESS on an accepted memory op, leave on ack or abort.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && mem_op) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (ack_hit || abort_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: memory request, pending instruction, write-back and flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_req            <= 1'b0;
         dmem_we             <= 1'b0;
         dmem_addr           <= '0;
         dmem_wdata          <= '0;
         wb_valid            <= 1'b0;
         wb_reg_write_enable <= 1'b0;
         wb_reg_dst          <= '0;
         wb_data             <= '0;
         flags_out           <= '0;
         pend_store          <= 1'b0;
         pend_rwe            <= 1'b0;
         pend_dst            <= '0;
      end else begin
         wb_valid <= 1'b0;

         if (accept) begin
            if (in_fl_write_enable) begin
               flags_out <= in_alu_flags;
            end
            if (mem_op) begin
               // A store wins over a load encoding and never writes the register file.
               dmem_req   <= 1'b1;
               dmem_we    <= in_mem_write_enable;
               dmem_addr  <= in_mem_addr;
               dmem_wdata <= in_mem_data;
               pend_store <= in_mem_write_enable;
               pend_rwe   <= in_reg_write_enable & ~in_mem_write_enable;
               pend_dst   <= in_reg_dst;
            end else begin
               wb_valid            <= 1'b1;
               wb_reg_write_enable <= in_reg_write_enable;
               wb_reg_dst          <= in_reg_dst;
               wb_data             <= in_alu_out;
            end
         end

         if (ack_hit) begin
            dmem_req            <= 1'b0;
            wb_valid            <= 1'b1;
            wb_reg_write_enable <= pend_rwe;
            wb_reg_dst          <= pend_dst;
            wb_data             <= pend_store ? 32'd0 : dmem_rdata;
         end else if (abort_hit) begin
            dmem_req            <= 1'b0;
            wb_valid            <= 1'b1;
            wb_reg_write_enable <= 1'b0;
            wb_reg_dst          <= pend_dst;
            wb_data             <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU retire, load with wait states,
// store, back-to-back stall, reset mid-access and the ACCESS watchdog
// (or indefinite wait when MEM_TIMEOUT_EN is not defined).
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_mem_write_enable;
   logic [1:0]  in_wb_res_mux;
   logic        in_reg_write_enable;
   logic        in_fl_write_enable;
   logic [31:0] in_alu_out;
   logic [5:0]  in_alu_flags;
   logic [31:0] in_mem_addr;
   logic [31:0] in_mem_data;
   logic [4:0]  in_reg_dst;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_reg_write_enable;
   logic [4:0]  wb_reg_dst;
   logic [31:0] wb_data;
   logic [5:0]  flags_out;
   logic        mem_error;

   int checks = 0;
   int errors = 0;

   mem_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_mem_write_enable (in_mem_write_enable),
      .in_wb_res_mux       (in_wb_res_mux),
      .in_reg_write_enable (in_reg_write_enable),
      .in_fl_write_enable  (in_fl_write_enable),
      .in_alu_out          (in_alu_out),
      .in_alu_flags        (in_alu_flags),
      .in_mem_addr         (in_mem_addr),
      .in_mem_data         (in_mem_data),
      .in_reg_dst          (in_reg_dst),
      .stall               (stall),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .dmem_rdata          (dmem_rdata),
      .dmem_ack            (dmem_ack),
      .wb_valid            (wb_valid),
      .wb_reg_write_enable (wb_reg_write_enable),
      .wb_reg_dst          (wb_reg_dst),
      .wb_data             (wb_data),
      .flags_out           (flags_out),
      .mem_error           (mem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic mwe, input logic [1:0] mux,
                         input logic rwe, input logic fwe, input logic [31:0] alu,
                         input logic [5:0] fl, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] dst);
      in_valid            = v;
      in_mem_write_enable = mwe;
      in_wb_res_mux       = mux;
      in_reg_write_enable = rwe;
      in_fl_write_enable  = fwe;
      in_alu_out          = alu;
      in_alu_flags        = fl;
      in_mem_addr         = addr;
      in_mem_data         = data;
      in_reg_dst          = dst;
   endtask

   initial begin
      rst        = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      set_op(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 5'd0);

      // Reset state, before any clock edge
      #3;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_flags", 32'(flags_out), 32'd0);
      chk("rst_mem_error", 32'(mem_error), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // ALU op retires at its accept edge
      set_op(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h1234, 6'h2A, 32'h0, 32'h0, 5'd3);
      #1;
      chk("alu_stall_pre", 32'(stall), 32'd0);
      tick();
      chk("alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("alu_wb_data", wb_data, 32'h1234);
      chk("alu_wb_dst", 32'(wb_reg_dst), 32'd3);
      chk("alu_wb_rwe", 32'(wb_reg_write_enable), 32'd1);
      chk("alu_flags", 32'(flags_out), 32'h2A);
      chk("alu_stall_post", 32'(stall), 32'd0);
      chk("alu_req", 32'(dmem_req), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("alu_wb_valid_drop", 32'(wb_valid), 32'd0);

      // Load at 0x40, ack in the third ACCESS cycle; flags must not change
      set_op(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h999, 6'h15, 32'h40, 32'h0, 5'd7);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_req", 32'(dmem_req), 32'd1);
         chk("ld_we", 32'(dmem_we), 32'd0);
         chk("ld_addr", dmem_addr, 32'h40);
         chk("ld_stall", 32'(stall), 32'd1);
         chk("ld_wb_valid_wait", 32'(wb_valid), 32'd0);
         if (i == 2) begin
            dmem_ack   = 1'b1;
            dmem_rdata = 32'hDEADBEEF;
         end
         tick();
      end
      dmem_ack = 1'b0;
      chk("ld_wb_valid", 32'(wb_valid), 32'd1);
      chk("ld_wb_data", wb_data, 32'hDEADBEEF);
      chk("ld_wb_dst", 32'(wb_reg_dst), 32'd7);
      chk("ld_wb_rwe", 32'(wb_reg_write_enable), 32'd1);
      chk("ld_req_drop", 32'(dmem_req), 32'd0);
      chk("ld_stall_drop", 32'(stall), 32'd0);
      chk("ld_flags_hold", 32'(flags_out), 32'h2A);

      // Ack while IDLE is ignored
      dmem_ack = 1'b1;
      tick();
      chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
      chk("idle_ack_stall", 32'(stall), 32'd0);
      dmem_ack = 1'b0;

      // Store at 0x80 (load encoding also set: store wins), immediate ack
      set_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 6'h0, 32'h80, 32'h55AA, 5'd9);
      tick();
      in_valid = 1'b0;
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_addr", dmem_addr, 32'h80);
      chk("st_wdata", dmem_wdata, 32'h55AA);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_0000;
      tick();
      dmem_ack = 1'b0;
      chk("st_wb_valid", 32'(wb_valid), 32'd1);
      chk("st_wb_rwe", 32'(wb_reg_write_enable), 32'd0);
      chk("st_wb_data", wb_data, 32'd0);
      chk("st_req_drop", 32'(dmem_req), 32'd0);

      // Load (updates flags) followed by an ALU op held by stall
      set_op(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0, 6'h01, 32'h100, 32'h0, 5'd4);
      tick();
      chk("b2b_flags_load", 32'(flags_out), 32'h01);
      set_op(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hABCD, 6'h3F, 32'h0, 32'h0, 5'd5);
      #1;
      chk("b2b_stall", 32'(stall), 32'd1);
      tick();
      chk("b2b_wait_wb_valid", 32'(wb_valid), 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      tick();
      dmem_ack = 1'b0;
      chk("b2b_ld_wb_valid", 32'(wb_valid), 32'd1);
      chk("b2b_ld_wb_data", wb_data, 32'hCAFEF00D);
      chk("b2b_ld_wb_dst", 32'(wb_reg_dst), 32'd4);
      chk("b2b_stall_drop", 32'(stall), 32'd0);
      tick();
      chk("b2b_alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("b2b_alu_wb_data", wb_data, 32'hABCD);
      chk("b2b_alu_wb_dst", 32'(wb_reg_dst), 32'd5);
      chk("b2b_flags_hold", 32'(flags_out), 32'h01);
      in_valid = 1'b0;
      tick();
      chk("b2b_idle_wb_valid", 32'(wb_valid), 32'd0);

      // Reset in the middle of ACCESS
      set_op(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 6'h0, 32'h200, 32'h0, 5'd8);
      tick();
      in_valid = 1'b0;
      chk("rma_req_before", 32'(dmem_req), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rma_req_async", 32'(dmem_req), 32'd0);
      chk("rma_stall_async", 32'(stall), 32'd0);
      chk("rma_wb_valid_async", 32'(wb_valid), 32'd0);
      chk("rma_flags_async", 32'(flags_out), 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("rma_wb_valid_after", 32'(wb_valid), 32'd0);
      chk("rma_req_after", 32'(dmem_req), 32'd0);
      dmem_ack = 1'b0;

      // Load with no ack: watchdog abort after 16 cycles, or indefinite wait
      set_op(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 6'h0, 32'h300, 32'h0, 5'd6);
      tick();
      in_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         chk("tmo_req_wait", 32'(dmem_req), 32'd1);
         chk("tmo_err_wait", 32'(mem_error), 32'd0);
         chk("tmo_wb_valid_wait", 32'(wb_valid), 32'd0);
         tick();
      end
      chk("tmo_req_last", 32'(dmem_req), 32'd1);
      tick();
      chk("tmo_mem_error", 32'(mem_error), 32'd1);
      chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
      chk("tmo_wb_rwe", 32'(wb_reg_write_enable), 32'd0);
      chk("tmo_req_drop", 32'(dmem_req), 32'd0);
      chk("tmo_stall_drop", 32'(stall), 32'd0);
      tick();
      chk("tmo_mem_error_drop", 32'(mem_error), 32'd0);
      chk("tmo_wb_valid_drop", 32'(wb_valid), 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         chk("wait_req", 32'(dmem_req), 32'd1);
         chk("wait_mem_error", 32'(mem_error), 32'd0);
         chk("wait_wb_valid", 32'(wb_valid), 32'd0);
         tick();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      tick();
      dmem_ack = 1'b0;
      chk("wait_ld_wb_valid", 32'(wb_valid), 32'd1);
      chk("wait_ld_wb_data", wb_data, 32'h1234_5678);
      chk("wait_ld_wb_dst", 32'(wb_reg_dst), 32'd6);
      chk("wait_mem_error_end", 32'(mem_error), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
